imu_sample_gen: RTL and testbench

Parametrised multi-channel IMU stimulus source and the successor to the single-channel free-running sample counter. It produces one sample frame of NUM_CH channel words per rate tick over a valid/ready stream. Counting is selectable between sawtooth, triangle and hold modes, and frames skipped under back-pressure are counted. It sits at the head of the IMU signal pipeline and feeds the filter and packetiser stages in simulation and on-board bring-up.

---
 rtl/imu_sample_gen.sv | 191 +++++++++++++++++++
 tb/tb_imu_sample_gen.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imu_sample_gen.sv
// ============================================================================
//  Module      : imu_sample_gen
//  Description : Multi-channel IMU stimulus source. A rate divider produces
//                one tick every DIV enabled cycles. Each tick accepted while
//                idle emits a frame of NUM_CH words over a valid/ready
//                stream. Word c of a frame with snapshot S is
//                (S + c*CH_STEP) mod (MAX_VALUE+1). The base counter runs in
//                sawtooth, triangle or hold mode. Ticks that arrive while a
//                frame is in flight are counted in a saturating drop counter.
//  Ports       : clk        - clock, rising edge
//                rst_n      - asynchronous active-low reset
//                enable_i   - gates the rate divider
//                mode_i     - 0 sawtooth, 1 triangle, 2/3 hold
//                m_valid_o  - sample word present
//                m_ready_i  - downstream accepts the word
//                m_data_o   - sample word
//                m_ch_o     - channel index of m_data_o
//                m_last_o   - last channel of the frame
//                drop_cnt_o - saturating count of ticks lost in SEND
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module imu_sample_gen #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_VALUE = 16'd1000,
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned CH_STEP   = 16'd100,
    parameter int unsigned DIV       = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     enable_i,
    input  logic [1:0]                               mode_i,
    output logic                                     m_valid_o,
    input  logic                                     m_ready_i,
    output logic [WIDTH-1:0]                         m_data_o,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] m_ch_o,
    output logic                                     m_last_o,
    output logic [15:0]                              drop_cnt_o
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CH_W-1:0]  C_CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [WIDTH-1:0] C_MAX      = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH:0]   C_MAX_EXT  = (WIDTH+1)'(MAX_VALUE);
    localparam logic [WIDTH:0]   C_MOD_EXT  = (WIDTH+1)'(MAX_VALUE + 1);
    localparam logic [WIDTH:0]   C_STEP_EXT = (WIDTH+1)'(CH_STEP);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [WIDTH-1:0] base_q;
    logic             dir_up_q;
    logic             m_valid_q;
    logic [WIDTH-1:0] m_data_q;
    logic [CH_W-1:0]  m_ch_q;
    logic [15:0]      drop_cnt_q;

    logic             tick;
    logic             handshake;
    logic             last;
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] m_data_d;
    logic [WIDTH-1:0] base_d;
    logic             dir_up_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    always_comb begin
        tick      = enable_i && (div_cnt_q == C_DIV_LAST);
        handshake = m_valid_q && m_ready_i;
        last      = m_valid_q && (m_ch_q == C_CH_LAST);

        // Both operands are <= MAX_VALUE, so one conditional subtraction
        // brings the sum back into range; the extra bit catches overflow.
        step_sum = {1'b0, m_data_q} + C_STEP_EXT;
        if (step_sum > C_MAX_EXT) begin
            m_data_d = WIDTH'(step_sum - C_MOD_EXT);
        end else begin
            m_data_d = step_sum[WIDTH-1:0];
        end

        base_d   = base_q;
        dir_up_d = 1'b1;
        case (mode_i)
            2'd0: begin
                base_d = (base_q == C_MAX) ? '0 : base_q + WIDTH'(1);
            end
            2'd1: begin
                // The endpoint is emitted once: the step that leaves an
                // endpoint already moves in the new direction.
                if (C_MAX == '0) begin
                    base_d = '0;
                end else if (dir_up_q) begin
                    if (base_q == C_MAX) begin
                        base_d   = base_q - WIDTH'(1);
                        dir_up_d = 1'b0;
                    end else begin
                        base_d = base_q + WIDTH'(1);
                    end
                end else begin
                    if (base_q == '0) begin
                        base_d = base_q + WIDTH'(1);
                    end else begin
                        base_d   = base_q - WIDTH'(1);
                        dir_up_d = 1'b0;
                    end
                end
            end
            default: begin
                base_d = base_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Rate divider: frozen while disabled, wraps on the tick cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else if (enable_i) begin
            div_cnt_q <= tick ? '0 : div_cnt_q + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM with registered stream outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            dir_up_q   <= 1'b1;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_ch_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tick) begin
                        m_data_q  <= base_q;
                        m_ch_q    <= '0;
                        m_valid_q <= 1'b1;
                        base_q    <= base_d;
                        dir_up_q  <= dir_up_d;
                        state_q   <= S_SEND;
                    end
                end
                S_SEND: begin
                    // A tick here is lost even on the final handshake edge.
                    if (tick && (drop_cnt_q != 16'hFFFF)) begin
                        drop_cnt_q <= drop_cnt_q + 16'd1;
                    end
                    if (handshake) begin
                        if (last) begin
                            m_valid_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end else begin
                            m_ch_q   <= m_ch_q + CH_W'(1);
                            m_data_q <= m_data_d;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign m_valid_o  = m_valid_q;
    assign m_data_o   = m_data_q;
    assign m_ch_o     = m_ch_q;
    assign m_last_o   = last;
    assign drop_cnt_o = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_imu_sample_gen.sv
// ============================================================================
//  Module      : tb_imu_sample_gen
//  Description : Self-checking bench for imu_sample_gen. A frame-level model
//                predicts every output each cycle; directed phases pin the
//                model with literal values; a second instance exercises the
//                single-channel triangle sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_imu_sample_gen;

    localparam int MAXV = 10;
    localparam int NCH  = 3;
    localparam int STEP = 4;
    localparam int DIVV = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        enable_i = 1'b1;
    logic [1:0]  mode_i = 2'd0;
    logic        m_ready_i = 1'b1;
    logic        m_valid_o;
    logic [15:0] m_data_o;
    logic [1:0]  m_ch_o;
    logic        m_last_o;
    logic [15:0] drop_cnt_o;

    logic        rst2_n = 1'b0;
    logic        t_valid;
    logic [15:0] t_data;
    logic [0:0]  t_ch;
    logic        t_last;
    logic [15:0] t_drop;

    imu_sample_gen #(
        .WIDTH(16), .MAX_VALUE(MAXV), .NUM_CH(NCH), .CH_STEP(STEP), .DIV(DIVV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .mode_i(mode_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
        .m_ch_o(m_ch_o), .m_last_o(m_last_o), .drop_cnt_o(drop_cnt_o)
    );

    imu_sample_gen #(
        .WIDTH(16), .MAX_VALUE(3), .NUM_CH(1), .CH_STEP(0), .DIV(1)
    ) dut_tri (
        .clk(clk), .rst_n(rst2_n), .enable_i(1'b1), .mode_i(2'd1),
        .m_valid_o(t_valid), .m_ready_i(1'b1), .m_data_o(t_data),
        .m_ch_o(t_ch), .m_last_o(t_last), .drop_cnt_o(t_drop)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level reference model
    // ------------------------------------------------------------------
    int md_div  = 0;
    int md_base = 0;
    int md_S    = 0;
    int md_c    = 0;
    int md_drop = 0;
    bit md_up   = 1'b1;
    bit md_busy = 1'b0;
    bit md_tk;

    // Triangle as a position on a closed path of length 2*MAX.
    task automatic advance_base(input logic [1:0] m);
        int p;
        case (m)
            2'd0: begin
                md_base = (md_base + 1) % (MAXV + 1);
                md_up   = 1'b1;
            end
            2'd1: begin
                if (MAXV == 0) begin
                    md_base = 0;
                end else begin
                    p       = md_up ? md_base : 2 * MAXV - md_base;
                    p       = (p + 1) % (2 * MAXV);
                    md_base = (p <= MAXV) ? p : 2 * MAXV - p;
                    md_up   = (p < MAXV);
                end
            end
            default: md_up = 1'b1;
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_div = 0; md_base = 0; md_S = 0; md_c = 0; md_drop = 0;
            md_up = 1'b1; md_busy = 1'b0;
        end else begin
            md_tk = enable_i && (md_div == DIVV - 1);
            if (enable_i) md_div = md_tk ? 0 : md_div + 1;
            if (!md_busy) begin
                if (md_tk) begin
                    md_S    = md_base;
                    md_c    = 0;
                    md_busy = 1'b1;
                    advance_base(mode_i);
                end
            end else begin
                if (md_tk && md_drop < 65535) md_drop++;
                if (m_ready_i) begin
                    if (md_c == NCH - 1) md_busy = 1'b0;
                    else md_c++;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("valid", m_valid_o, md_busy);
        if (md_busy) begin
            chk("data", m_data_o, (md_S + md_c * STEP) % (MAXV + 1));
            chk("ch", m_ch_o, md_c);
            chk("last", m_last_o, md_c == NCH - 1);
        end
        chk("drop_cnt", drop_cnt_o, md_drop);
    end

    // ------------------------------------------------------------------
    // Single-channel triangle instance: 0,1,2,3,2,1,0,1,2
    // ------------------------------------------------------------------
    bit tri_done = 1'b0;
    initial begin
        int exp_tri [9] = '{0, 1, 2, 3, 2, 1, 0, 1, 2};
        int k;
        int n;
        k = 0;
        n = 0;
        wait (rst2_n === 1'b1);
        while (k < 9 && n < 60) begin
            @(negedge clk);
            n++;
            if (t_valid) begin
                chk("tri_word", t_data, exp_tri[k]);
                chk("tri_last", t_last, 1);
                chk("tri_ch", t_ch, 0);
                k++;
            end
        end
        chk("tri_word_count", k, 9);
        tri_done = 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Directed and random stimulus
    // ------------------------------------------------------------------
    initial begin
        int words [$];
        bit lasts [$];
        int first_valid;
        int i;
        int n;
        int cnt;
        logic [15:0] d0;
        logic [15:0] hd;
        logic [1:0]  hc;

        repeat (3) @(negedge clk);
        chk("reset_valid", m_valid_o, 0);
        chk("reset_drop", drop_cnt_o, 0);
        #2;
        rst_n  = 1'b1;
        rst2_n = 1'b1;

        // First frame timing and sawtooth snapshots 0..10,0
        first_valid = -1;
        i = 0;
        while (words.size() < 36 && i < 300) begin
            @(negedge clk);
            i++;
            if (m_valid_o) begin
                if (first_valid < 0) first_valid = i;
                words.push_back(int'(m_data_o));
                lasts.push_back(m_last_o);
            end
        end
        chk("first_valid_edge", first_valid, 4);
        chk("collected_words", words.size(), 36);
        if (words.size() == 36) begin
            chk("frame0_w0", words[0], 0);
            chk("frame0_w1", words[1], 4);
            chk("frame0_w2", words[2], 8);
            chk("frame0_last0", lasts[0], 0);
            chk("frame0_last1", lasts[1], 0);
            chk("frame0_last2", lasts[2], 1);
            for (int k = 0; k < 12; k++) chk("saw_snapshot", words[3 * k], k % 11);
            chk("frame9_w0", words[27], 9);
            chk("frame9_w1", words[28], 2);
            chk("frame9_w2", words[29], 6);
        end

        // Back-pressure mid-frame
        n = 0;
        while (!(m_valid_o && m_ch_o == 2'd1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_found_ch1", m_valid_o && m_ch_o == 2'd1, 1);
        m_ready_i = 1'b0;
        d0 = drop_cnt_o;
        hd = m_data_o;
        hc = m_ch_o;
        repeat (10) begin
            @(negedge clk);
            chk("bp_data_stable", m_data_o, hd);
            chk("bp_ch_stable", m_ch_o, hc);
        end
        chk("bp_drops_2_or_3", (drop_cnt_o - d0 >= 2) && (drop_cnt_o - d0 <= 3), 1);
        m_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_resume_ch", m_ch_o, 2);

        // Hold mode from S=5
        n = 0;
        while (!(m_valid_o && m_ch_o == 2'd0 && m_data_o == 16'd4) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("hold_found_s4", m_valid_o && m_ch_o == 2'd0 && m_data_o == 16'd4, 1);
        mode_i = 2'd2;
        cnt = 0;
        n = 0;
        while (cnt < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (m_valid_o && m_ch_o == 2'd0) begin
                chk("hold_snapshot", m_data_o, 5);
                cnt++;
            end
        end
        chk("hold_frames", cnt, 3);

        // Enable low mid-frame: frame completes, nothing new
        enable_i = 1'b0;
        n = 0;
        while (m_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("en_off_frame_done", m_valid_o, 0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_valid_o) cnt++;
        end
        chk("en_off_no_valid", cnt, 0);
        enable_i = 1'b1;
        n = 0;
        while (!m_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("en_resume_within_div", (n >= 1) && (n <= DIVV), 1);

        // Randomised traffic
        for (int r = 0; r < 2000; r++) begin
            @(negedge clk);
            m_ready_i = ($urandom_range(0, 9) < 7);
            enable_i  = ($urandom_range(0, 9) < 9);
            if ($urandom_range(0, 19) == 0) mode_i = 2'($urandom_range(0, 3));
        end

        // Asynchronous reset mid-frame
        mode_i    = 2'd0;
        enable_i  = 1'b1;
        m_ready_i = 1'b1;
        n = 0;
        while (!(m_valid_o && m_ch_o == 2'd1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_found_ch1", m_valid_o && m_ch_o == 2'd1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", m_valid_o, 0);
        chk("rst_async_drop", drop_cnt_o, 0);
        chk("rst_async_ch", m_ch_o, 0);
        chk("rst_async_data", m_data_o, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        n = 0;
        while (!m_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_first_valid_edge", n, 4);
        chk("rst_first_data", m_data_o, 0);
        chk("rst_first_ch", m_ch_o, 0);

        repeat (5) @(negedge clk);
        chk("tri_done", tri_done, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
